interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
- REQ-001: Parameter N_SRC, default 4, SHALL set the number of interrupt sources; legal range 1..16.
- REQ-002: Parameter ID_W, default 2, SHALL set the source-ID width; it SHALL be at least ceil(log2(N_SRC)), minimum 1.
- REQ-003: Parameter MASK_RST, default all ones (N_SRC bits), SHALL set the enable-mask reset value.
- REQ-004: CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: CLR  input  1  SHALL be the asynchronous, active-low reset.
- REQ-006: Sw  input  N_SRC  SHALL carry the asynchronous interrupt source lines, one bit per source.
- REQ-007: Write  input  1  SHALL be the mask-register write strobe, sampled on CLK.
- REQ-008: WData  input  N_SRC  SHALL carry the mask value loaded when Write=1.
- REQ-009: Ack  input  1  SHALL be the processor acknowledge of the current request.
- REQ-010: Done  input  1  SHALL be the processor end-of-service indication (return from handler).
- REQ-011: IRQ  output  1  SHALL be the interrupt request to the processor.
- REQ-012: IntID  output  ID_W  SHALL carry the ID of the requested or in-service source.
- REQ-013: InService  output  1  SHALL be high while a handler is executing.
- REQ-014: Pending  output  N_SRC  SHALL mirror the pending register.
- REQ-015: Overrun  output  N_SRC  SHALL mirror the sticky overrun flags.

Function
- REQ-016: Each Sw bit SHALL pass through a two-flop synchroniser (s1, s2) plus a history flop (h); event = s2 & ~h (rising edge only).
- REQ-017: An event on source i SHALL set Pending[i] on the same edge that h captures s2. Pending latency is exactly 3 rising edges after the first edge that samples Sw high.
- REQ-018: An event on source i while Pending[i]=1 SHALL set Overrun[i]; Pending[i] SHALL remain 1. Overrun is sticky.
- REQ-019: Write=1 SHALL load Mask<=WData and clear all Overrun bits on the same edge.
- REQ-020: Mask SHALL gate requests only; masked sources SHALL still set Pending and Overrun.
- REQ-021: The FSM SHALL have three states: IDLE, REQ and SERVICE, encoded as 2 bits.
- REQ-022: In IDLE, if (Pending & Mask) != 0, the next state SHALL be REQ, and IntID SHALL latch the lowest set index (index 0 is highest priority).
- REQ-023: IRQ SHALL equal (state==REQ) and SHALL be registered (state-decoded, no combinational path from Sw).
- REQ-024: In REQ, Ack=1 SHALL clear Pending[IntID] and move to SERVICE; IntID SHALL hold through SERVICE.
- REQ-025: A request in REQ SHALL be committed: mask changes while in REQ SHALL NOT withdraw IRQ or change IntID.
- REQ-026: In SERVICE, Done=1 SHALL return to IDLE. Re-arbitration SHALL occur in IDLE on the following edge, so IRQ is low for at least 1 cycle between requests.
- REQ-027: InService SHALL equal (state==SERVICE). No nesting is allowed; new events during SERVICE only set Pending.
- REQ-028: Ack outside REQ and Done outside SERVICE SHALL be ignored. If Ack and Done are both high in REQ, only Ack SHALL act.
- REQ-029: If an event on source IntID coincides with its Ack-clear, the set SHALL win: Pending stays 1 and Overrun is not set.
- REQ-030: If N_SRC is less than 2^ID_W, IntID SHALL never exceed N_SRC-1.

Reset
- REQ-031: CLR=0 SHALL asynchronously force state=IDLE, IRQ=0, IntID=0, InService=0, Pending=0, Overrun=0, Mask=MASK_RST, and s1=s2=h=0, regardless of the current state.
- REQ-032: A source held high across reset release SHALL register as one event (history resets to 0).
- REQ-033: Reset asserted mid-REQ or mid-SERVICE SHALL drop IRQ and InService immediately, without waiting for a clock edge.

Verification
- REQ-034: Sw=4'b0100 raised before edge 1 -> Pending=4'b0100 after edge 3; IRQ=1 and IntID=2 after edge 4; Ack pulse -> Pending=0, InService=1; Done pulse -> IDLE, IRQ=0.
- REQ-035: Sw[3] and Sw[1] rising together -> IntID=1 first. After Ack/Done for source 1, IRQ deasserts for 1 cycle, then IRQ=1 with IntID=3.
- REQ-036: Write with WData=4'b1110, then event on Sw[0] -> Pending[0]=1 and IRQ stays 0. Write with WData=4'b1111 -> IRQ=1 with IntID=0.
- REQ-037: Second rising edge on Sw[2] before Ack -> Overrun=4'b0100 and Pending[2]=1. A Write clears Overrun to 0.
- REQ-038: CLR driven low while in SERVICE (between edges) -> IRQ, InService, Pending and IntID read 0 before the next edge; Mask reads back as MASK_RST.
- REQ-039: Parameter sweep with N_SRC=1, ID_W=1 and N_SRC=16, ID_W=4 -> the source-15-only event yields IntID=15, and priority order holds across all 16 sources.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Processor-side bundle of the interrupt controller: source lines, mask write
// port, request/acknowledge/end-of-service handshake and status mirrors.
interface interrupt_controller_if #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
);
    // Handshake: IRQ rises with IntID valid and stays up until the processor
    // answers with Ack (IRQ & Ack = request taken); InService then stays high
    // until Done, and IRQ is low for at least one cycle before the next request.
    logic [N_SRC-1:0] Sw;
    logic             Write;
    logic [N_SRC-1:0] WData;
    logic             Ack;
    logic             Done;
    logic             IRQ;
    logic [ID_W-1:0]  IntID;
    logic             InService;
    logic [N_SRC-1:0] Pending;
    logic [N_SRC-1:0] Overrun;
    logic [N_SRC-1:0] Mask;

    modport master (
        output Sw, Write, WData, Ack, Done,
        input  IRQ, IntID, InService, Pending, Overrun, Mask
    );

    modport slave (
        input  Sw, Write, WData, Ack, Done,
        output IRQ, IntID, InService, Pending, Overrun, Mask
    );
endinterface

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: synchronised rising-edge source detection,
// pending/overrun tracking, enable mask and a one-deep REQ/SERVICE handshake.
module interrupt_controller #(
    parameter int               N_SRC    = 4,
    parameter int               ID_W     = 2,
    parameter logic [N_SRC-1:0] MASK_RST = '1
) (
    input  logic                 CLK,
    input  logic                 CLR,
    interrupt_controller_if.slave bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] s1_q, s1_d, s2_q, s2_d, h_q, h_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             irq_q, irq_d;
    logic             insvc_q, insvc_d;

    logic [N_SRC-1:0] evt;
    logic [N_SRC-1:0] req_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [ID_W-1:0]  pick;

    assign evt     = s2_q & ~h_q;
    assign req_vec = pending_q & mask_q;

    // Scan from the top down so the lowest requesting index is the last write.
    always_comb begin
        pick = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) pick = ID_W'(i);
        end
    end

    always_comb begin
        s1_d    = bus.Sw;
        s2_d    = s1_q;
        h_d     = s2_q;
        state_d = state_q;
        id_d    = id_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d = REQ;
                    id_d    = pick;
                end
            end
            REQ: begin
                if (bus.Ack) begin
                    state_d = SERVICE;
                    for (int i = 0; i < N_SRC; i++) begin
                        if (id_q == ID_W'(i)) clr_vec[i] = 1'b1;
                    end
                end
            end
            SERVICE: begin
                if (bus.Done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh event beats the Ack-clear of the same source and is not an overrun.
        pending_d = (pending_q & ~clr_vec) | evt;
        overrun_d = bus.Write ? '0 : (overrun_q | (evt & pending_q & ~clr_vec));
        mask_d    = bus.Write ? bus.WData : mask_q;
        irq_d     = (state_d == REQ);
        insvc_d   = (state_d == SERVICE);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            h_q       <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= MASK_RST;
            id_q      <= '0;
            irq_q     <= 1'b0;
            insvc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            h_q       <= h_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            irq_q     <= irq_d;
            insvc_q   <= insvc_d;
        end
    end

    assign bus.IRQ       = irq_q;
    assign bus.IntID     = id_q;
    assign bus.InService = insvc_q;
    assign bus.Pending   = pending_q;
    assign bus.Overrun   = overrun_q;
    assign bus.Mask      = mask_q;
    assign dbg_state     = state_q;
endmodule
